// File: rtl/fifo_centre_pkg.sv
// Shared definitions for the FIFO centre read/write controllers.
package fifo_centre_pkg;

    localparam int unsigned NUM_STREAMS = 8;
    localparam int unsigned AT_INDEX    = 8;

    localparam logic [7:0] DEFAULT_TAG_BASE = 8'hF0;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        READ,
        CAPTURE,
        SEND,
        DONE
    } sched_state_e;

endpackage

// File: rtl/ds_read_scheduler_if.sv
// FIFO-centre and transmitter-side signals of the datastream read scheduler.
interface ds_read_scheduler_if;
    import fifo_centre_pkg::*;

    logic                     enable;
    logic [NUM_STREAMS-1:0]   stream_mask;
    logic [AT_INDEX:0]        empty_flag;
    logic [8*NUM_STREAMS-1:0] ds_data;
    logic [AT_INDEX:0]        read_enable;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     busy;
    logic [2:0]               current_stream;

    modport master (
        input  enable, stream_mask, empty_flag, ds_data, tx_ready,
        output read_enable, tx_data, tx_valid, busy, current_stream
    );

    modport slave (
        output enable, stream_mask, empty_flag, ds_data, tx_ready,
        input  read_enable, tx_data, tx_valid, busy, current_stream
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping.
module rr_priority_pick
    import fifo_centre_pkg::*;
(
    input  logic [NUM_STREAMS-1:0] req,
    input  logic [2:0]             ptr,
    output logic [2:0]             grant,
    output logic                   found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        // k = NUM_STREAMS wraps back to ptr itself, so it is searched last.
        for (int unsigned k = 1; k <= NUM_STREAMS; k++) begin
            if (!found && req[ptr + 3'(k)]) begin
                grant = ptr + 3'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ds_read_scheduler.sv
// Drains DS0-DS7 round-robin into one tagged byte stream for the UART transmitter.
module ds_read_scheduler
    import fifo_centre_pkg::*;
#(
    parameter int unsigned BYTES_PER_GRANT = 2,
    parameter logic [7:0]  TAG_BASE        = DEFAULT_TAG_BASE
) (
    input  logic          clock,
    input  logic          reset,
    ds_read_scheduler_if.master bus
);

    sched_state_e      state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        id_q, id_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [AT_INDEX:0] rd_en;
    logic              tx_valid;

    logic [NUM_STREAMS-1:0] cand;
    logic [2:0]             pick_grant;
    logic                   pick_found;

    assign cand = bus.stream_mask & ~bus.empty_flag[NUM_STREAMS-1:0];

    rr_priority_pick u_pick (
        .req   (cand),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .found (pick_found)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        rd_en     = '0;
        tx_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && pick_found) begin
                    id_d      = pick_grant;
                    tx_data_d = TAG_BASE | {5'b0, pick_grant};
                    state_d   = TAG;
                end
            end
            TAG: begin
                tx_valid = 1'b1;
                if (bus.tx_ready) state_d = READ;
            end
            READ: begin
                rd_en[id_q] = 1'b1;
                state_d     = CAPTURE;
            end
            CAPTURE: begin
                tx_data_d = bus.ds_data[8*id_q +: 8];
                state_d   = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                if (bus.tx_ready) begin
                    cnt_d = cnt_q + 8'd1;
                    // Empty flag has had two cycles to settle since the last strobe.
                    if ((cnt_q + 8'd1 == 8'(BYTES_PER_GRANT)) || bus.empty_flag[id_q])
                        state_d = DONE;
                    else
                        state_d = READ;
                end
            end
            DONE: begin
                ptr_d   = id_q;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd7;
            id_q      <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.read_enable    = rd_en;
    assign bus.tx_data        = tx_data_q;
    assign bus.tx_valid       = tx_valid;
    assign bus.busy           = (state_q != IDLE);
    assign bus.current_stream = id_q;

endmodule
